// File: rtl/dds_multichannel.sv
// Multi-channel direct digital synthesiser. Each channel runs its own phase
// accumulator (tone or linear chirp) into a shared waveform table loaded from
// the AXI clock domain, then scales by a signed amplitude. Configuration is
// shadowed every cycle and moved to the active set for all channels at once
// on commit, so multi-channel tones stay phase coherent.
module dds_multichannel #(
  parameter int NUM_CH   = 2,
  parameter int ACC_W    = 32,
  parameter int LUT_AW   = 10,
  parameter int SAMPLE_W = 16
) (
  input  logic                       DAC_clk,
  input  logic                       rst_n,
  input  logic                       AXI_clk,
  input  logic                       en,
  input  logic                       sync,
  input  logic                       commit,
  input  logic [2*NUM_CH-1:0]        Mode,
  input  logic [ACC_W*NUM_CH-1:0]    FreqCntrl,
  input  logic [ACC_W*NUM_CH-1:0]    FreqStop,
  input  logic [ACC_W*NUM_CH-1:0]    SweepStep,
  input  logic [ACC_W*NUM_CH-1:0]    PhaseCntrl,
  input  logic [SAMPLE_W*NUM_CH-1:0] AmplCntrl,
  input  logic [SAMPLE_W*NUM_CH-1:0] DirectValue,
  input  logic                       LUTWriteEn,
  input  logic [LUT_AW-1:0]          LUTAddress,
  input  logic [SAMPLE_W-1:0]        LUTData,
  output logic [SAMPLE_W*NUM_CH-1:0] SampleOut,
  output logic                       SampleValid,
  output logic [NUM_CH-1:0]          SweepWrap
);

  localparam int CFG_W = NUM_CH * (2 + 4*ACC_W + 2*SAMPLE_W);
  localparam logic [1:0] M_DIRECT = 2'd0;
  localparam logic [1:0] M_CHIRP  = 2'd2;
  localparam logic [1:0] M_MUTE   = 2'd3;

  // Q1.15 x Q1.15 renormalisation; -1 x -1 is the only product that overflows.
  function automatic logic signed [SAMPLE_W-1:0] renorm_sat(
    input logic signed [2*SAMPLE_W-1:0] p
  );
    if (p[2*SAMPLE_W-1 -: 2] == 2'b01)
      return {1'b0, {(SAMPLE_W-1){1'b1}}};
    return p[2*SAMPLE_W-2 -: SAMPLE_W];
  endfunction

  logic [CFG_W-1:0]           shadow_q, active_q;
  logic [2*NUM_CH-1:0]        mode_a;
  logic [ACC_W*NUM_CH-1:0]    freq_a, stop_a, step_a, phase_a, freq_s;
  logic [SAMPLE_W*NUM_CH-1:0] ampl_a, dval_a;
  logic                       vld_p0_q, vld_p1_q, vld_p2_q, vld_p3_q, vld_p4_q;
  logic                       sample_valid_q;

  assign {mode_a, freq_a, stop_a, step_a, phase_a, ampl_a, dval_a} = active_q;
  assign freq_s = shadow_q[CFG_W-2*NUM_CH-1 -: ACC_W*NUM_CH];

  // Shadow inputs every cycle; the active set only changes on commit.
  always_ff @(posedge DAC_clk) begin
    if (!rst_n) begin
      shadow_q <= '0;
      active_q <= '0;
    end else begin
      shadow_q <= {Mode, FreqCntrl, FreqStop, SweepStep, PhaseCntrl, AmplCntrl, DirectValue};
      if (commit) active_q <= shadow_q;
    end
  end

  // Valid travels beside the samples; dropping en kills SampleValid at once.
  always_ff @(posedge DAC_clk) begin
    if (!rst_n) begin
      vld_p0_q       <= 1'b0;
      vld_p1_q       <= 1'b0;
      vld_p2_q       <= 1'b0;
      vld_p3_q       <= 1'b0;
      vld_p4_q       <= 1'b0;
      sample_valid_q <= 1'b0;
    end else begin
      vld_p0_q       <= en;
      vld_p1_q       <= vld_p0_q;
      vld_p2_q       <= vld_p1_q;
      vld_p3_q       <= vld_p2_q;
      vld_p4_q       <= vld_p3_q;
      sample_valid_q <= vld_p4_q & en;
    end
  end

  assign SampleValid = sample_valid_q;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    logic [1:0]                 mode;
    logic [ACC_W-1:0]           freq, stop, step, phase, freq_new;
    logic signed [SAMPLE_W-1:0] ampl, dval;
    logic [ACC_W-1:0]           acc_q, acc_d, fcur_q, fcur_d;
    logic [ACC_W:0]             sweep_sum;
    logic                       wrap_q, wrap_d;
    logic [LUT_AW-1:0]          addr_p1_q;
    logic [1:0]                 mode_p1_q, mode_p2_q, mode_p3_q, mode_p4_q;
    logic signed [SAMPLE_W-1:0] ampl_p1_q, ampl_p2_q, ampl_p3_q;
    logic signed [SAMPLE_W-1:0] dval_p1_q, dval_p2_q, dval_p3_q, dval_p4_q;
    logic signed [SAMPLE_W-1:0] rd_p2_q, rd_p3_q, out_q;
    logic signed [2*SAMPLE_W-1:0] prod_p4_q;
    logic [SAMPLE_W-1:0]        mem [2**LUT_AW];

    assign mode     = mode_a[2*k +: 2];
    assign freq     = freq_a[k*ACC_W +: ACC_W];
    assign stop     = stop_a[k*ACC_W +: ACC_W];
    assign step     = step_a[k*ACC_W +: ACC_W];
    assign phase    = phase_a[k*ACC_W +: ACC_W];
    assign freq_new = freq_s[k*ACC_W +: ACC_W];
    assign ampl     = ampl_a[k*SAMPLE_W +: SAMPLE_W];
    assign dval     = dval_a[k*SAMPLE_W +: SAMPLE_W];
    assign sweep_sum = {1'b0, fcur_q} + {1'b0, step};

    // Stage A next state: sync beats the increment, commit reloads the chirp start.
    always_comb begin
      acc_d  = acc_q;
      fcur_d = fcur_q;
      wrap_d = 1'b0;
      if (!en) begin
        acc_d  = '0;
        fcur_d = freq;
      end else if (sync) begin
        acc_d = '0;
      end else if (mode == M_CHIRP) begin
        acc_d = acc_q + fcur_q;
        if (sweep_sum >= {1'b0, stop}) begin
          fcur_d = freq;
          wrap_d = 1'b1;
        end else begin
          fcur_d = sweep_sum[ACC_W-1:0];
        end
      end else begin
        acc_d  = acc_q + freq;
        fcur_d = freq;
      end
      if (commit) fcur_d = freq_new;
    end

    // Stage A: accumulator, current chirp frequency and wrap pulse.
    always_ff @(posedge DAC_clk) begin
      if (!rst_n) begin
        acc_q  <= '0;
        fcur_q <= '0;
        wrap_q <= 1'b0;
      end else begin
        acc_q  <= acc_d;
        fcur_q <= fcur_d;
        wrap_q <= wrap_d;
      end
    end

    // Table copy for this channel; every copy sees every AXI write.
    always_ff @(posedge AXI_clk) begin
      if (LUTWriteEn) mem[LUTAddress] <= LUTData;
    end

    // Stages B..E: phase offset, two-cycle table read, multiply, renormalise/select.
    always_ff @(posedge DAC_clk) begin
      if (!rst_n) begin
        addr_p1_q <= '0;
        mode_p1_q <= '0;
        mode_p2_q <= '0;
        mode_p3_q <= '0;
        mode_p4_q <= '0;
        ampl_p1_q <= '0;
        ampl_p2_q <= '0;
        ampl_p3_q <= '0;
        dval_p1_q <= '0;
        dval_p2_q <= '0;
        dval_p3_q <= '0;
        dval_p4_q <= '0;
        rd_p2_q   <= '0;
        rd_p3_q   <= '0;
        prod_p4_q <= '0;
        out_q     <= '0;
      end else begin
        // B: phase offset, keep the table address bits
        addr_p1_q <= LUT_AW'((acc_q + phase) >> (ACC_W - LUT_AW));
        mode_p1_q <= mode;
        ampl_p1_q <= ampl;
        dval_p1_q <= dval;
        // C: table read
        rd_p2_q   <= mem[addr_p1_q];
        mode_p2_q <= mode_p1_q;
        ampl_p2_q <= ampl_p1_q;
        dval_p2_q <= dval_p1_q;
        // D: table output register
        rd_p3_q   <= rd_p2_q;
        mode_p3_q <= mode_p2_q;
        ampl_p3_q <= ampl_p2_q;
        dval_p3_q <= dval_p2_q;
        // E1: full-width signed product
        prod_p4_q <= (2*SAMPLE_W)'(rd_p3_q) * (2*SAMPLE_W)'(ampl_p3_q);
        mode_p4_q <= mode_p3_q;
        dval_p4_q <= dval_p3_q;
        // E: mode select and renormalise
        case (mode_p4_q)
          M_DIRECT: out_q <= dval_p4_q;
          M_MUTE:   out_q <= '0;
          default:  out_q <= renorm_sat(prod_p4_q);
        endcase
      end
    end

    assign SampleOut[k*SAMPLE_W +: SAMPLE_W] = out_q;
    assign SweepWrap[k] = wrap_q;
  end

endmodule

// File: tb/tb_dds_multichannel.sv
// Directed bench for dds_multichannel: ramp table tone run, phase offset,
// deferred commit, chirp wrap timing, direct-mode alignment, mid-run reset and
// a table of multiply/saturation/mode vectors.
module tb_dds_multichannel;
  localparam int NCH = 2;
  localparam int AW  = 32;
  localparam int LA  = 10;
  localparam int SW  = 16;

  logic              DAC_clk = 1'b0, AXI_clk = 1'b0;
  logic              rst_n, en, sync, commit;
  logic [2*NCH-1:0]  Mode;
  logic [AW*NCH-1:0] FreqCntrl, FreqStop, SweepStep, PhaseCntrl;
  logic [SW*NCH-1:0] AmplCntrl, DirectValue;
  logic              LUTWriteEn;
  logic [LA-1:0]     LUTAddress;
  logic [SW-1:0]     LUTData;
  logic [SW*NCH-1:0] SampleOut;
  logic              SampleValid;
  logic [NCH-1:0]    SweepWrap;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [1:0]  mode;
    logic [15:0] smp;
    logic [15:0] amp;
    logic [15:0] dv;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs [12];
  int   units [9];

  dds_multichannel #(.NUM_CH(NCH), .ACC_W(AW), .LUT_AW(LA), .SAMPLE_W(SW)) dut (
    .DAC_clk(DAC_clk), .rst_n(rst_n), .AXI_clk(AXI_clk), .en(en), .sync(sync),
    .commit(commit), .Mode(Mode), .FreqCntrl(FreqCntrl), .FreqStop(FreqStop),
    .SweepStep(SweepStep), .PhaseCntrl(PhaseCntrl), .AmplCntrl(AmplCntrl),
    .DirectValue(DirectValue), .LUTWriteEn(LUTWriteEn), .LUTAddress(LUTAddress),
    .LUTData(LUTData), .SampleOut(SampleOut), .SampleValid(SampleValid),
    .SweepWrap(SweepWrap)
  );

  always #5 DAC_clk = ~DAC_clk;
  always #7 AXI_clk = ~AXI_clk;

  function automatic logic [15:0] mul16(input logic [15:0] s, input logic [15:0] a);
    longint p;
    p = longint'($signed(s)) * longint'($signed(a));
    if (s == 16'h8000 && a == 16'h8000) return 16'h7FFF;
    return 16'(p >>> 15);
  endfunction

  function automatic logic [15:0] ramp(input int a);
    return mul16(16'((a % 1024) * 64), 16'h7FFF);
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", nm, act, req);
    end
  endtask

  task automatic tick();
    @(posedge DAC_clk);
    @(negedge DAC_clk);
  endtask

  task automatic pulse(input logic c, input logic s);
    commit = c;
    sync   = s;
    tick();
    commit = 1'b0;
    sync   = 1'b0;
  endtask

  task automatic set_ch(input int k, input logic [1:0] m, input logic [31:0] f,
                        input logic [31:0] stp, input logic [31:0] inc,
                        input logic [31:0] ph, input logic [15:0] amp,
                        input logic [15:0] dv);
    Mode[2*k +: 2]          = m;
    FreqCntrl[AW*k +: AW]   = f;
    FreqStop[AW*k +: AW]    = stp;
    SweepStep[AW*k +: AW]   = inc;
    PhaseCntrl[AW*k +: AW]  = ph;
    AmplCntrl[SW*k +: SW]   = amp;
    DirectValue[SW*k +: SW] = dv;
  endtask

  // Expects the synchronising edge to have just happened (via pulse).
  task automatic run_check(input string nm, input int inc, input int n);
    repeat (4) tick();
    for (int j = 0; j < n; j++) begin
      tick();
      check({nm, "_ch0"}, {16'h0, SampleOut[15:0]},  {16'h0, ramp(inc*j)});
      check({nm, "_ch1"}, {16'h0, SampleOut[31:16]}, {16'h0, ramp(inc*j + 256)});
    end
  endtask

  initial begin
    //            mode   sample    ampl      direct    expected
    vecs[0]  = '{2'd1, 16'h8000, 16'h8000, 16'h0000, 16'h7FFF};
    vecs[1]  = '{2'd1, 16'h4000, 16'h4000, 16'h0000, 16'h2000};
    vecs[2]  = '{2'd1, 16'h7FFF, 16'h7FFF, 16'h0000, 16'h7FFE};
    vecs[3]  = '{2'd1, 16'h8000, 16'h7FFF, 16'h0000, 16'h8001};
    vecs[4]  = '{2'd1, 16'h4000, 16'hC000, 16'h0000, 16'hE000};
    vecs[5]  = '{2'd1, 16'h0100, 16'h7FFF, 16'h0000, 16'h00FF};
    vecs[6]  = '{2'd1, 16'hFF00, 16'h7FFF, 16'h0000, 16'hFF00};
    vecs[7]  = '{2'd1, 16'h1234, 16'h0000, 16'h0000, 16'h0000};
    vecs[8]  = '{2'd1, 16'h8000, 16'h4000, 16'h0000, 16'hC000};
    vecs[9]  = '{2'd1, 16'h7FFF, 16'h8000, 16'h0000, 16'h8001};
    vecs[10] = '{2'd0, 16'h7FFF, 16'h7FFF, 16'h1234, 16'h1234};
    vecs[11] = '{2'd3, 16'h7FFF, 16'h7FFF, 16'h5555, 16'h0000};
    units = '{1, 3, 6, 10, 11, 13, 16, 20, 21};

    rst_n = 1'b0; en = 1'b0; sync = 1'b0; commit = 1'b0;
    Mode = '0; FreqCntrl = '0; FreqStop = '0; SweepStep = '0; PhaseCntrl = '0;
    AmplCntrl = '0; DirectValue = '0;
    LUTWriteEn = 1'b0; LUTAddress = '0; LUTData = '0;
    repeat (3) tick();
    check("reset_out",   SampleOut,   32'h0);
    check("reset_valid", SampleValid, 32'h0);
    check("reset_wrap",  SweepWrap,   32'h0);
    rst_n = 1'b1;

    // Ramp table.
    for (int i = 0; i < 1024; i++) begin
      @(negedge AXI_clk);
      LUTWriteEn = 1'b1; LUTAddress = LA'(i); LUTData = SW'(i * 64);
    end
    @(negedge AXI_clk);
    LUTWriteEn = 1'b0;
    @(negedge DAC_clk);

    // Tone on both channels, ch1 a quarter cycle ahead.
    set_ch(0, 2'd1, 32'h0040_0000, 0, 0, 32'h0, 16'h7FFF, 16'h0);
    set_ch(1, 2'd1, 32'h0040_0000, 0, 0, 32'h4000_0000, 16'h7FFF, 16'h0);
    tick();
    pulse(1'b1, 1'b0);
    en = 1'b1;
    for (int i = 1; i <= 1036; i++) begin
      tick();
      if (i == 5) check("valid_before", SampleValid, 32'h0);
      if (i == 6) check("valid_rise",   SampleValid, 32'h1);
      if (i >= 6) begin
        check("ramp_ch0", {16'h0, SampleOut[15:0]},  {16'h0, ramp(i - 5)});
        check("ramp_ch1", {16'h0, SampleOut[31:16]}, {16'h0, ramp(i - 5 + 256)});
      end
    end

    // New frequency staged but not committed: output rate unchanged.
    set_ch(0, 2'd1, 32'h0080_0000, 0, 0, 32'h0, 16'h7FFF, 16'h0);
    set_ch(1, 2'd1, 32'h0080_0000, 0, 0, 32'h4000_0000, 16'h7FFF, 16'h0);
    tick(); tick();
    pulse(1'b0, 1'b1);
    run_check("nocommit", 1, 4);
    pulse(1'b1, 1'b1);
    run_check("commit_sync", 2, 4);

    // Chirp on ch0.
    en = 1'b0;
    tick();
    check("valid_fall", SampleValid, 32'h0);
    set_ch(0, 2'd2, 32'h0010_0000, 32'h0050_0000, 32'h0010_0000, 32'h0, 16'h7FFF, 16'h0);
    tick();
    pulse(1'b1, 1'b0);
    en = 1'b1;
    for (int c = 1; c <= 14; c++) begin
      tick();
      if (c <= 10)
        check("chirp_wrap", SweepWrap, (c == 4 || c == 8) ? 32'h1 : 32'h0);
      if (c >= 6)
        check("chirp_out", {16'h0, SampleOut[15:0]}, {16'h0, ramp(units[c-6] >> 2)});
    end

    // Direct value on ch1 stays aligned with ch0 through the pipeline.
    set_ch(0, 2'd1, 32'h0040_0000, 0, 0, 32'h0, 16'h7FFF, 16'h0);
    set_ch(1, 2'd1, 32'h0040_0000, 0, 0, 32'h4000_0000, 16'h7FFF, 16'h0);
    tick();
    pulse(1'b1, 1'b1);
    set_ch(1, 2'd0, 32'h0040_0000, 0, 0, 32'h4000_0000, 16'h7FFF, 16'h1234);
    tick();
    pulse(1'b0, 1'b1);
    tick();
    pulse(1'b1, 1'b0);
    tick(); tick();
    for (int j = 0; j < 4; j++) begin
      tick();
      check("direct_ch0", {16'h0, SampleOut[15:0]}, {16'h0, ramp(j)});
      check("direct_ch1", {16'h0, SampleOut[31:16]},
            {16'h0, (j < 2) ? ramp(j + 256) : 16'h1234});
    end

    // Mid-run reset, then table must still be intact.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("midreset_out",   SampleOut,   32'h0);
    check("midreset_valid", SampleValid, 32'h0);
    check("midreset_wrap",  SweepWrap,   32'h0);
    set_ch(1, 2'd1, 32'h0040_0000, 0, 0, 32'h4000_0000, 16'h7FFF, 16'h0);
    tick();
    pulse(1'b1, 1'b1);
    run_check("after_reset", 1, 4);

    // Multiply, saturation and mode vectors.
    for (int j = 0; j < 12; j++) begin
      @(negedge AXI_clk);
      LUTWriteEn = 1'b1; LUTAddress = LA'(100 + j); LUTData = vecs[j].smp;
    end
    @(negedge AXI_clk);
    LUTWriteEn = 1'b0;
    @(negedge DAC_clk);
    for (int j = 0; j < 12; j++) begin
      for (int k = 0; k < NCH; k++)
        set_ch(k, vecs[j].mode, 32'h0, 0, 0, 32'((100 + j) << 22), vecs[j].amp, vecs[j].dv);
      tick();
      pulse(1'b1, 1'b1);
      repeat (6) tick();
      check($sformatf("vec%0d_ch0", j), {16'h0, SampleOut[15:0]},  {16'h0, vecs[j].exp});
      check($sformatf("vec%0d_ch1", j), {16'h0, SampleOut[31:16]}, {16'h0, vecs[j].exp});
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
